// File: rtl/demux_8_1_pkg.sv
// Shared constants and the select-to-lane helper for the 1-to-8 demultiplexer.
package demux_pkg;

   localparam int N_OUT = 8;
   localparam int SEL_W = 3;

   function automatic logic [N_OUT-1:0] lane_mask(input logic [SEL_W-1:0] sel);
      logic [N_OUT-1:0] mask;
      mask = '0;
      mask[sel] = 1'b1;
      return mask;
   endfunction

endpackage

// File: rtl/demux_8_1_if.sv
// Bus carrying the steered data, the lane select and the registered lane outputs.
interface demux_8_1_if
   import demux_pkg::*;
   #(parameter int W = 1);

   logic [W-1:0]       A;
   logic [SEL_W-1:0]   s;
   logic [N_OUT*W-1:0] d;
   logic [N_OUT-1:0]   sel_oh;

   modport master (output A, output s, input d, input sel_oh);
   modport slave  (input A, input s, output d, output sel_oh);

endinterface

// File: rtl/demux_8_1_decoder.sv
// Combinational 3-bit to 8-bit one-hot decoder driving lane gating and sel_oh.
module decoder_3to8
   import demux_pkg::*;
(
   input  logic [SEL_W-1:0] sel_i,
   output logic [N_OUT-1:0] oneHot_o
);

   assign oneHot_o = lane_mask(sel_i);

endmodule

// File: rtl/demux_8_1.sv
// Registered 1-to-8 demultiplexer: A lands on lane s one clock later, other lanes read zero.
module demux_8_1
   import demux_pkg::*;
   #(parameter int W = 1)
(
   input  logic        clk,
   input  logic        rst_n,
   demux_8_1_if.slave  bus
);

   logic [N_OUT-1:0]   laneSel;
   logic [N_OUT*W-1:0] d_d;
   logic [N_OUT*W-1:0] d_q;
   logic [N_OUT-1:0]   selOh_d;
   logic [N_OUT-1:0]   selOh_q;

   decoder_3to8 u_decoder (
      .sel_i    (bus.s),
      .oneHot_o (laneSel)
   );

   always_comb begin
      d_d = '0;
      for (int i = 0; i < N_OUT; i++) begin
         d_d[i*W +: W] = bus.A & {W{laneSel[i]}};
      end
      selOh_d = laneSel;
   end

   // Reset parks the select on lane 0 so sel_oh stays one-hot even while held.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         d_q     <= '0;
         selOh_q <= lane_mask(SEL_W'(0));
      end else begin
         d_q     <= d_d;
         selOh_q <= selOh_d;
      end
   end

   assign bus.d      = d_q;
   assign bus.sel_oh = selOh_q;

endmodule

// File: tb/tb_demux_8_1.sv
// Self-checking bench: W=1 and W=4 demultiplexers against an arithmetic reference model.
module tb_demux_8_1;

   logic clk;
   logic rst_n;

   demux_8_1_if #(.W(1)) bus1 ();
   demux_8_1_if #(.W(4)) bus4 ();

   demux_8_1 #(.W(1)) dut1 (.clk(clk), .rst_n(rst_n), .bus(bus1.slave));
   demux_8_1 #(.W(4)) dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4.slave));

   int total = 0;
   int bad   = 0;

   logic [7:0]  expD1;
   logic [31:0] expD4;
   logic [7:0]  expSel;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Drive one (rst_n, A, s) set, take one edge and work out what the lanes must now hold.
   task automatic applyStimulus(input logic rn, input logic a1, input logic [3:0] a4,
                                input logic [2:0] sel);
      rst_n  = rn;
      bus1.A = a1;
      bus4.A = a4;
      bus1.s = sel;
      bus4.s = sel;
      @(posedge clk);
      #1;
      if (!rn) begin
         expD1  = 8'h00;
         expD4  = 32'h0;
         expSel = 8'h01;
      end else begin
         expD1  = 8'(32'(a1) << sel);
         expD4  = 32'(a4) << (4 * int'(sel));
         expSel = 8'(1 << sel);
      end
   endtask

   task automatic checkOutput(input string tag);
      total++;
      assert (bus1.d === expD1) else begin
         bad++;
         $error("FAIL %s d(W=1) got=%h expected=%h", tag, bus1.d, expD1);
      end
      total++;
      assert (bus1.sel_oh === expSel) else begin
         bad++;
         $error("FAIL %s sel_oh(W=1) got=%h expected=%h", tag, bus1.sel_oh, expSel);
      end
      total++;
      assert (bus4.d === expD4) else begin
         bad++;
         $error("FAIL %s d(W=4) got=%h expected=%h", tag, bus4.d, expD4);
      end
      total++;
      assert (bus4.sel_oh === expSel) else begin
         bad++;
         $error("FAIL %s sel_oh(W=4) got=%h expected=%h", tag, bus4.sel_oh, expSel);
      end
      total++;
      assert ($onehot(bus1.sel_oh) && $onehot(bus4.sel_oh)) else begin
         bad++;
         $error("FAIL %s onehot got=%h/%h expected one-hot", tag, bus1.sel_oh, bus4.sel_oh);
      end
   endtask

   initial begin
      logic       rn;
      logic       a1;
      logic [3:0] a4;
      logic [2:0] sel;

      rst_n  = 1'b0;
      bus1.A = 1'b0;
      bus4.A = 4'h0;
      bus1.s = 3'd0;
      bus4.s = 3'd0;

      // Reset held for two edges with live data on the inputs.
      applyStimulus(1'b0, 1'b1, 4'hF, 3'b101);
      checkOutput("reset_edge1");
      applyStimulus(1'b0, 1'b1, 4'hF, 3'b101);
      checkOutput("reset_edge2");

      for (int i = 0; i < 8; i++) begin
         applyStimulus(1'b1, 1'b0, 4'h0, 3'(i));
         checkOutput($sformatf("sweep_s%0d_a0", i));
         applyStimulus(1'b1, 1'b1, 4'(i + 1), 3'(i));
         checkOutput($sformatf("sweep_s%0d_a1", i));
      end

      // Select change between edges must not reach the outputs until the next edge.
      applyStimulus(1'b1, 1'b1, 4'h3, 3'b000);
      checkOutput("latency_before");
      #2;
      bus1.s = 3'b110;
      bus4.s = 3'b110;
      #1;
      checkOutput("latency_midcycle");
      applyStimulus(1'b1, 1'b1, 4'h3, 3'b110);
      checkOutput("latency_after");

      applyStimulus(1'b1, 1'b1, 4'h7, 3'b011);
      checkOutput("stream_s3");
      applyStimulus(1'b0, 1'b1, 4'h7, 3'b011);
      checkOutput("midstream_reset");
      applyStimulus(1'b1, 1'b1, 4'h7, 3'b011);
      checkOutput("reset_release");

      applyStimulus(1'b1, 1'b0, 4'hA, 3'b100);
      checkOutput("wide_A_lane4");
      total++;
      assert (bus4.d === 32'h000A_0000) else begin
         bad++;
         $error("FAIL wide_lane4_const got=%h expected=%h", bus4.d, 32'h000A_0000);
      end
      applyStimulus(1'b1, 1'b0, 4'h5, 3'b001);
      checkOutput("wide_5_lane1");
      total++;
      assert (bus4.d === 32'h0000_0050) else begin
         bad++;
         $error("FAIL wide_lane1_const got=%h expected=%h", bus4.d, 32'h0000_0050);
      end

      for (int n = 0; n < 1000; n++) begin
         rn  = ($urandom_range(15) != 0);
         a1  = 1'($urandom);
         a4  = 4'($urandom);
         sel = 3'($urandom);
         applyStimulus(rn, a1, a4, sel);
         checkOutput($sformatf("random_%0d", n));
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
